// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the DAC segment controller: FSM state encoding,
// default segment split and the clip limit helper.
package dac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_PWRUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_PWRDN = 2'd3
  } state_e;

  localparam int NBIN_DEF   = 7;
  localparam int NTHERM_DEF = 17;
  localparam int CODE_W     = 12;

  // Largest representable code: every thermometer element on plus all binary LSBs.
  function automatic int max_code(input int ntherm, input int nbin);
    return ntherm * (1 << nbin) + (1 << nbin) - 1;
  endfunction

  localparam int MAX_CODE_DEF = max_code(NTHERM_DEF, NBIN_DEF);

endpackage

// File: rtl/therm_encoder.sv
// Combinational thermometer mask: msb_i elements set. With DAC_SEGMENT_CTRL_DWA_EN
// the run of set bits starts at ptr_i and wraps modulo NTHERM.
module therm_encoder #(
  parameter int NTHERM = 17,
  parameter int MW     = 5,
  parameter int PW     = 5
) (
  input  logic [MW-1:0]     msb_i,
`ifdef DAC_SEGMENT_CTRL_DWA_EN
  input  logic [PW-1:0]     ptr_i,
`endif
  output logic [NTHERM-1:0] mask_o
);

  always_comb begin
    int off;
    mask_o = '0;
    off    = 0;
    for (int i = 0; i < NTHERM; i++) begin
`ifdef DAC_SEGMENT_CTRL_DWA_EN
      // distance of element i from the rotation pointer, going upward with wrap
      off = i - int'(ptr_i);
      if (off < 0) off = off + NTHERM;
`else
      off = i;
`endif
      mask_o[i] = (off < int'(msb_i));
    end
  end

endmodule

// File: rtl/dac_segment_ctrl.sv
// DAC segment controller: power sequencing FSM plus segmented (thermometer + binary)
// code registers. Define DAC_SEGMENT_CTRL_DWA_EN to rotate thermometer elements (DWA).
module dac_segment_ctrl
  import dac_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int NTHERM     = NTHERM_DEF,
  parameter int NBIN       = NBIN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [11:0]       code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              pdb,
  output logic [NBIN-1:0]   databin,
  output logic [NBIN-1:0]   databinb,
  output logic [NTHERM-1:0] datatherm,
  output logic [NTHERM-1:0] datathermb,
  output logic              sat,
  output logic [1:0]        state
);

  localparam int MW   = $clog2(NTHERM + 1);
  localparam int PW   = (NTHERM > 1) ? $clog2(NTHERM) : 1;
  localparam int MAXC = max_code(NTHERM, NBIN);
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                pdb_q;
  logic [NBIN-1:0]     bin_q, bin_d, binb_q;
  logic [NTHERM-1:0]   therm_q, therm_d, thermb_q;
  logic                sat_q, sat_d;

  logic                acc, over;
  logic [11:0]         clip, msb_full;
  logic [MW-1:0]       msb;
  logic [NTHERM-1:0]   mask;

  assign code_ready = (state_q == ST_RUN) && en;
  assign acc        = code_valid && code_ready;
  assign over       = (32'(code_in) > 32'(MAXC));
  assign clip       = over ? 12'(MAXC) : code_in;
  assign msb_full   = clip >> NBIN;
  assign msb        = msb_full[MW-1:0];

`ifdef DAC_SEGMENT_CTRL_DWA_EN
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int s;
    s     = int'(ptr_q) + int'(msb);
    if (s >= NTHERM) s = s - NTHERM;
    ptr_d = ptr_q;
    if (acc) ptr_d = PW'(s);
    if (state_d == ST_OFF && state_q != ST_OFF) ptr_d = '0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;

  therm_encoder #(.NTHERM(NTHERM), .MW(MW), .PW(PW)) u_enc (
    .msb_i (msb),
    .ptr_i (ptr_q),
    .mask_o(mask)
  );
`else
  therm_encoder #(.NTHERM(NTHERM), .MW(MW), .PW(PW)) u_enc (
    .msb_i (msb),
    .mask_o(mask)
  );
`endif

  // Power sequencing; a falling en aborts PWRUP but PWRDN always runs to OFF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: if (en) begin
        state_d = ST_PWRUP;
        cnt_d   = RELOAD;
      end
      ST_PWRUP: begin
        if (!en) begin
          state_d = ST_PWRDN;
          cnt_d   = RELOAD;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RUN: if (!en) begin
        state_d = ST_PWRDN;
        cnt_d   = RELOAD;
      end
      ST_PWRDN: begin
        if (cnt_q == 8'd0) state_d = ST_OFF;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Data path forced to the zero code whenever the next state is not RUN.
  always_comb begin
    bin_d   = bin_q;
    therm_d = therm_q;
    sat_d   = 1'b0;
    if (state_d != ST_RUN) begin
      bin_d   = '0;
      therm_d = '0;
    end else if (acc) begin
      bin_d   = clip[NBIN-1:0];
      therm_d = mask;
      sat_d   = over;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      pdb_q    <= 1'b0;
      bin_q    <= '0;
      binb_q   <= '1;
      therm_q  <= '0;
      thermb_q <= '1;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pdb_q    <= (state_d != ST_OFF);
      bin_q    <= bin_d;
      binb_q   <= ~bin_d;
      therm_q  <= therm_d;
      thermb_q <= ~therm_d;
      sat_q    <= sat_d;
    end
  end

  assign pdb        = pdb_q;
  assign databin    = bin_q;
  assign databinb   = binb_q;
  assign datatherm  = therm_q;
  assign datathermb = thermb_q;
  assign sat        = sat_q;
  assign state      = state_q;

endmodule
